// File: rtl/ax_level_controller.sv
// rtl/ax_level_controller.sv - windowed error-rate governor driving the AXLEVEL hardware write port
module ax_level_controller #(
  parameter int AX_LEVEL_WIDTH  = 3,
  parameter int DATA_WIDTH      = 32,
  parameter int ERR_NUM_WIDTH   = 2,
  parameter int WINDOW_LOG2     = 10,
  parameter int COOLDOWN_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     axThreshold,
  input  logic [AX_LEVEL_WIDTH-1:0] axLevel,
  input  logic [ERR_NUM_WIDTH-1:0]  errorNum,
  input  logic                      swAxLevelWrite,
  output logic                      axLevelEn,
  output logic [AX_LEVEL_WIDTH-1:0] axLevelData
);

  localparam int COOL_W = $clog2(COOLDOWN_CYCLES + 1);
  localparam logic [AX_LEVEL_WIDTH-1:0] LEVEL_MAX = '1;

  typedef enum logic [1:0] {IDLE, COUNT, DECIDE, COOLDOWN} state_t;

  state_t                    state, state_n;
  logic [WINDOW_LOG2-1:0]    cycle_cnt, cycle_cnt_n;
  logic [DATA_WIDTH-1:0]     err_cnt, err_cnt_n;
  logic [COOL_W-1:0]         cool_cnt, cool_cnt_n;
  logic                      en_reg, en_n;
  logic [AX_LEVEL_WIDTH-1:0] data_reg, data_n;
  logic [DATA_WIDTH:0]       err_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cycle_cnt <= '0;
      err_cnt   <= '0;
      cool_cnt  <= '0;
      en_reg    <= 1'b0;
      data_reg  <= '0;
    end else begin
      state     <= state_n;
      cycle_cnt <= cycle_cnt_n;
      err_cnt   <= err_cnt_n;
      cool_cnt  <= cool_cnt_n;
      en_reg    <= en_n;
      data_reg  <= data_n;
    end
  end

  always_comb begin
    state_n     = state;
    cycle_cnt_n = cycle_cnt;
    err_cnt_n   = err_cnt;
    cool_cnt_n  = cool_cnt;
    // The strobe is a single-cycle pulse, so it defaults low every cycle.
    en_n        = 1'b0;
    data_n      = data_reg;
    err_sum     = {1'b0, err_cnt} + (DATA_WIDTH+1)'(errorNum);

    if (state != IDLE && axThreshold == '0) begin
      state_n     = IDLE;
      cycle_cnt_n = '0;
      err_cnt_n   = '0;
      cool_cnt_n  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (axThreshold != '0) begin
            state_n     = COUNT;
            cycle_cnt_n = '0;
            err_cnt_n   = '0;
          end
        end
        COUNT: begin
          if (swAxLevelWrite) begin
            cycle_cnt_n = '0;
            err_cnt_n   = '0;
          end else begin
            cycle_cnt_n = cycle_cnt + WINDOW_LOG2'(1);
            err_cnt_n   = err_sum[DATA_WIDTH] ? '1 : err_sum[DATA_WIDTH-1:0];
            if (&cycle_cnt) state_n = DECIDE;
          end
        end
        DECIDE: begin
          cycle_cnt_n = '0;
          err_cnt_n   = '0;
          if (swAxLevelWrite) begin
            state_n = COUNT;
          end else if (err_cnt > axThreshold && axLevel != '0) begin
            en_n       = 1'b1;
            data_n     = axLevel - AX_LEVEL_WIDTH'(1);
            state_n    = COOLDOWN;
            cool_cnt_n = COOL_W'(COOLDOWN_CYCLES);
          end else if (err_cnt < (axThreshold >> 1) && axLevel != LEVEL_MAX) begin
            en_n       = 1'b1;
            data_n     = axLevel + AX_LEVEL_WIDTH'(1);
            state_n    = COOLDOWN;
            cool_cnt_n = COOL_W'(COOLDOWN_CYCLES);
          end else begin
            state_n = COUNT;
          end
        end
        COOLDOWN: begin
          if (cool_cnt == COOL_W'(1)) begin
            state_n     = COUNT;
            cool_cnt_n  = '0;
            cycle_cnt_n = '0;
            err_cnt_n   = '0;
          end else begin
            cool_cnt_n = cool_cnt - COOL_W'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // A software write in the same cycle always wins over the hardware strobe.
  assign axLevelEn   = en_reg & ~swAxLevelWrite;
  assign axLevelData = data_reg;

endmodule

// File: doc/ax_level_controller.md
# ax_level_controller

Hardware governor for the approximation level register (AXLEVEL) in the CSR unit. It drives the CSR unit's hardware write port, `axLevelEn`/`axLevelData`, and is the producer at the far end of that port. Over fixed windows it counts approximation error events reported by the backend and compares the count with the software-programmed `axThreshold`. It then steps the level down (less approximation) or up (more approximation) by one, with hysteresis and a cooldown between changes.

## Interface
Parameters:
- `AX_LEVEL_WIDTH`, default 3: width of the level. 0 is exact; `2^AX_LEVEL_WIDTH-1` is the maximum approximation.
- `DATA_WIDTH`, default 32: width of the threshold and the error counter.
- `ERR_NUM_WIDTH`, default 2: width of the per-cycle error count.
- `WINDOW_LOG2`, default 10: the observation window is `2^WINDOW_LOG2` cycles.
- `COOLDOWN_CYCLES`, default 64: dead time after a level change. Must be ≥1.

Ports:
- `clk`  in  1  clock. One clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `axThreshold`  in  DATA_WIDTH  allowed errors per window, taken from the CSR `axthreshold`. 0 disables the controller.
- `axLevel`  in  AX_LEVEL_WIDTH  current CSR `axlevel`.
- `errorNum`  in  ERR_NUM_WIDTH  approximation error events this cycle.
- `swAxLevelWrite`  in  1  a software CSR write to AXLEVEL takes effect this cycle.
- `axLevelEn`  out  1  one-cycle hardware write strobe to the CSR unit.
- `axLevelData`  out  AX_LEVEL_WIDTH  new level; valid while `axLevelEn` is high.

## Operation
- States:
  - IDLE: disabled.
  - COUNT: observing a window.
  - DECIDE: evaluating the window, 1 cycle.
  - COOLDOWN: dead time after a change.
- Registers:
  - `cycleCnt`, WINDOW_LOG2 bits.
  - `errCnt`, DATA_WIDTH bits.
  - `coolCnt`.
  - `enReg`, `dataReg`.
- Reset: the state goes to IDLE; all counters, `enReg` and `dataReg` go to 0. Outputs `axLevelEn`=0 and `axLevelData`=0.
- IDLE:
  - If `axThreshold`≠0, go to COUNT with `cycleCnt`=`errCnt`=0.
- COUNT:
  - Each cycle, `cycleCnt`+1.
  - Each cycle, `errCnt`+=`errorNum`, unsigned. The add saturates at all-ones and never wraps.
  - When `cycleCnt`==2^WINDOW_LOG2−1, go to DECIDE. That cycle's `errorNum` is included.
- DECIDE, using an unsigned compare:
  - If `errCnt`>`axThreshold` and `axLevel`>0, the new level is `axLevel`−1.
  - Else if `errCnt`<(`axThreshold`>>1) and `axLevel`<max, the new level is `axLevel`+1.
  - Otherwise there is no change.
  - On a change: set `enReg`=1 and `dataReg`=new level, then go to COOLDOWN with `coolCnt`=COOLDOWN_CYCLES.
  - With no change: go to COUNT with the counters cleared.
  - With `axThreshold`==1, the lower bound is 0, so the level never increases.
- COOLDOWN:
  - `enReg` clears after its first cycle.
  - `errorNum` is ignored.
  - `coolCnt` decrements; when it reaches 1, go to COUNT with the counters cleared.
- Disable: `axThreshold`==0 observed in any non-IDLE state:
  - go to IDLE next cycle;
  - clear the counters;
  - suppress any pending strobe.
- Software override:
  - `swAxLevelWrite` in COUNT restarts the window: the counters clear and the state stays COUNT.
  - `swAxLevelWrite` in DECIDE discards the decision and goes to COUNT with the counters cleared.
  - `swAxLevelWrite` in COOLDOWN has no effect.
- Output gating:
  - `axLevelEn` = `enReg` & ~`swAxLevelWrite`. This is the only combinational path, and it exists so a hardware strobe never overrides a same-cycle software write.
  - `axLevelData` = `dataReg`.

## Timing
- Let cycle 0 be the first COUNT cycle of a window, with N=2^WINDOW_LOG2.
  - Errors are sampled in cycles 0..N−1.
  - DECIDE is cycle N.
  - `axLevelEn` is high in cycle N+1 only.
  - COOLDOWN occupies cycles N+1..N+COOLDOWN_CYCLES.
  - The next window starts at cycle N+COOLDOWN_CYCLES+1.
- With no change, the next window starts at cycle N+1.
- The CSR unit registers the strobe, so the updated `axLevel` is visible at N+2. No decision samples `axLevel` before N+1+N, which leaves no hazard.
- Asynchronous reset mid-operation: outputs drop to 0 immediately, without waiting for a clock edge. After release, the block returns to IDLE behaviour on the first edge.
- At most one strobe per N+COOLDOWN_CYCLES+1 cycles.

## Test plan
Parameters: WINDOW_LOG2=4 (N=16), COOLDOWN_CYCLES=4, AX_LEVEL_WIDTH=3.
- Level down: `axThreshold`=5, `axLevel`=3, `errorNum`=1 on 6 cycles of the window. Required: `axLevelEn`=1 for exactly one cycle at cycle 17 with `axLevelData`=2; the next window starts at cycle 21.
- Level up and clamp: `axThreshold`=8, 2 errors in the window, `axLevel`=3. Required: a strobe with data 4. Repeat with `axLevel`=7: no strobe, and the next window starts at cycle 17.
- Hysteresis band and saturation: `axThreshold`=5 with 4 errors gives no strobe. `axThreshold`=0xFFFFFFFF with `errorNum`=3 every cycle over many windows: `errCnt` never wraps and no level-down strobe occurs.
- Software override: `swAxLevelWrite` at cycle 10 restarts the window, so DECIDE falls at cycle 27. In a separate run, `swAxLevelWrite` coincides with the strobe cycle: `axLevelEn` must be 0.
- Disable: with `axThreshold`=0 from reset, the block stays in IDLE and never strobes. Dropping `axThreshold` to 0 at cycle 15 gives no strobe, and the block is in IDLE by cycle 16.
- Reset: assert `rst` asynchronously during COOLDOWN and during the strobe cycle. `axLevelEn` and `axLevelData` must read 0 before the next clock edge; after release there is no strobe until a full window has elapsed.
